bus_arbiter4_16: RTL and testbench

Round-robin arbiter and sequencer for a shared 16-bit datapath built from a 4-way mux16 tree. Four requesters compete for one 16-bit bus, for example CPU data port, instruction fetch, DMA and screen refresh in front of shared RAM. The block registers a one-hot grant and drives the mux select from it. It enforces a bounded hold time, so no requester can starve the others.

---
 rtl/bus_arbiter4_16.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter4_16.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter4_16.sv
// Four-way round-robin bus arbiter with bounded hold time.
// A registered one-hot grant drives the select of a 4-way data mux.
// An owner keeps the bus while its request stays high. It is preempted after
// MAX_HOLD consecutive cycles whenever another requester is waiting.
module bus_arbiter4_16 #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;

    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_found;
    logic       others_req;

    // State register: synchronous active-low reset restarts the search at requester 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= '1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Round-robin search: first active request after last_q, wrapping back to last_q
    always_comb begin
        cand      = last_q;
        win_idx   = last_q;
        win_found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Any requester other than the current owner is waiting
    always_comb begin
        others_req = |(req & ~(4'b0001 << sel_q));
    end

    // Next-state logic: grant, release/handoff, preemption and hold counting
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    sel_d   = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    last_d  = win_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                // last_q equals sel_q while granted, so the search already starts after the owner
                if (!req[sel_q]) begin
                    hold_d = '0;
                    if (others_req) begin
                        sel_d  = win_idx;
                        gnt_d  = 4'b0001 << win_idx;
                        last_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if ((hold_q == HOLD_LIMIT) && others_req) begin
                    sel_d  = win_idx;
                    gnt_d  = 4'b0001 << win_idx;
                    last_d = win_idx;
                    hold_d = '0;
                end else if (hold_q != HOLD_LIMIT) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Output logic: data mux follows the registered owner and live inputs
    always_comb begin
        bus_out   = '0;
        bus_valid = 1'b0;
        if (state_q == GRANT) begin
            bus_valid = req[sel_q];
            unique case (sel_q)
                2'd0: bus_out = d0;
                2'd1: bus_out = d1;
                2'd2: bus_out = d2;
                2'd3: bus_out = d3;
                default: bus_out = '0;
            endcase
        end
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_bus_arbiter4_16.sv
// Self-checking bench for bus_arbiter4_16: directed scenarios plus a randomized
// run compared against a cycle-level round-robin model.
module tb_bus_arbiter4_16;

    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] d_v [4];
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] bus_out;
    logic        bus_valid;

    int checks;
    int failures;

    // Reference model state: owner index (-1 when idle), select, pointer, cycles owned
    int m_owner;
    int m_sel;
    int m_last;
    int m_held;

    bus_arbiter4_16 #(
        .WIDTH(16),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .d0(d_v[0]),
        .d1(d_v[1]),
        .d2(d_v[2]),
        .d3(d_v[3]),
        .gnt(gnt),
        .sel(sel),
        .bus_out(bus_out),
        .bus_valid(bus_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  w;
        bit  others;
        if (!rst_n) begin
            m_owner = -1; m_sel = 0; m_last = 3; m_held = 0;
        end else if (m_owner < 0) begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_last = w; m_held = 1;
            end
        end else begin
            others = 1'b0;
            for (int j = 0; j < 4; j++) if (j != m_owner && req[j]) others = 1'b1;
            if (!req[m_owner]) begin
                if (others) begin
                    w = pick(req, m_owner);
                    m_owner = w; m_sel = w; m_last = w; m_held = 1;
                end else begin
                    m_owner = -1;
                end
            end else if (m_held >= MAX_HOLD && others) begin
                w = pick(req, m_owner);
                m_owner = w; m_sel = w; m_last = w; m_held = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = 4'b1111;
        d_v[0] = 16'h1234;
        d_v[1] = 16'h1111;
        d_v[2] = 16'h2222;
        d_v[3] = 16'h3333;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt cycle %0d got %b want 0000", c, gnt); end
            checks++;
            if (bus_out !== 16'h0000) begin failures++; $display("FAIL reset_bus cycle %0d got %h want 0000", c, bus_out); end
            checks++;
            if (bus_valid !== 1'b0) begin failures++; $display("FAIL reset_valid cycle %0d got %b want 0", c, bus_valid); end
            checks++;
            if (sel !== 2'b00) begin failures++; $display("FAIL reset_sel cycle %0d got %b want 00", c, sel); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
        checks++;
        if (sel !== 2'b00) begin failures++; $display("FAIL reset_first_sel got %b want 00", sel); end
        checks++;
        if (bus_out !== 16'h1234) begin failures++; $display("FAIL reset_first_bus got %h want 1234", bus_out); end
    endtask

    task automatic test_single();
        do_reset();
        d_v[2] = 16'hABCD;
        req = 4'b0100;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got %b want 0100", gnt); end
        checks++;
        if (sel !== 2'b10) begin failures++; $display("FAIL single_sel got %b want 10", sel); end
        checks++;
        if (bus_out !== 16'hABCD) begin failures++; $display("FAIL single_bus got %h want abcd", bus_out); end
        checks++;
        if (bus_valid !== 1'b1) begin failures++; $display("FAIL single_valid got %b want 1", bus_valid); end
        req = 4'b0000;
        #1;
        checks++;
        if (bus_valid !== 1'b0) begin failures++; $display("FAIL drop_valid got %b want 0", bus_valid); end
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL drop_gnt_held got %b want 0100", gnt); end
        checks++;
        if (bus_out !== 16'hABCD) begin failures++; $display("FAIL drop_bus_held got %h want abcd", bus_out); end
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL release_gnt got %b want 0000", gnt); end
        checks++;
        if (bus_out !== 16'h0000) begin failures++; $display("FAIL release_bus got %h want 0000", bus_out); end
        checks++;
        if (sel !== 2'b10) begin failures++; $display("FAIL release_sel_hold got %b want 10", sel); end
    endtask

    task automatic test_fairness();
        logic [15:0] pat [4];
        int          exp_owner;
        pat[0] = 16'h0000; pat[1] = 16'hFFFF; pat[2] = 16'hAAAA; pat[3] = 16'h5555;
        do_reset();
        for (int i = 0; i < 4; i++) d_v[i] = pat[i];
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            exp_owner = (c / MAX_HOLD) % 4;
            checks++;
            if (gnt !== 4'(1 << exp_owner)) begin
                failures++; $display("FAIL fair_gnt cycle %0d got %b want %b", c, gnt, 4'(1 << exp_owner));
            end
            checks++;
            if (bus_out !== pat[exp_owner]) begin
                failures++; $display("FAIL fair_bus cycle %0d got %h want %h", c, bus_out, pat[exp_owner]);
            end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        req = 4'b0010;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL handoff_start got %b want 0010", gnt); end
        req = 4'b1011;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL handoff_keep got %b want 0010", gnt); end
        req = 4'b1001;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b1000) begin failures++; $display("FAIL handoff_skip_gnt got %b want 1000", gnt); end
        checks++;
        if (sel !== 2'b11) begin failures++; $display("FAIL handoff_skip_sel got %b want 11", sel); end
    endtask

    task automatic test_lone_owner();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (gnt !== 4'b0001) begin failures++; $display("FAIL lone_gnt cycle %0d got %b want 0001", c, gnt); end
        end
        req = 4'b1001;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b1000) begin failures++; $display("FAIL lone_preempt got %b want 1000", gnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL mid_owner got %b want 0100", gnt); end
        req   = 4'b1111;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL mid_reset_gnt got %b want 0000", gnt); end
        checks++;
        if (bus_out !== 16'h0000) begin failures++; $display("FAIL mid_reset_bus got %h want 0000", bus_out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_restart_gnt got %b want 0001", gnt); end
        checks++;
        if (sel !== 2'b00) begin failures++; $display("FAIL mid_restart_sel got %b want 00", sel); end
    endtask

    task automatic test_random();
        logic [3:0]  exp_gnt;
        logic [15:0] exp_bus;
        logic        exp_valid;
        do_reset();
        m_owner = -1; m_sel = 0; m_last = 3; m_held = 0;
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) < 3) req[i] = ~req[i];
                d_v[i] = 16'($urandom);
            end
            #1;
            exp_gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            exp_bus   = (m_owner < 0) ? 16'h0000 : d_v[m_owner];
            exp_valid = (m_owner >= 0) && req[m_owner];
            checks++;
            if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt cycle %0d got %b want %b", c, gnt, exp_gnt); end
            checks++;
            if (sel !== 2'(m_sel)) begin failures++; $display("FAIL rand_sel cycle %0d got %0d want %0d", c, sel, m_sel); end
            checks++;
            if (bus_out !== exp_bus) begin failures++; $display("FAIL rand_bus cycle %0d got %h want %h", c, bus_out, exp_bus); end
            checks++;
            if (bus_valid !== exp_valid) begin failures++; $display("FAIL rand_valid cycle %0d got %b want %b", c, bus_valid, exp_valid); end
            @(posedge clk);
            model_step();
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        for (int i = 0; i < 4; i++) d_v[i] = '0;
        test_reset();
        test_single();
        test_fairness();
        test_handoff();
        test_lone_owner();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
